// File: rtl/msm_bucket_scheduler.sv
// msm_bucket_scheduler: issues Pippenger bucket-accumulation operations for one
// window to a shared pipelined point adder. Tracks buckets with an addition in
// flight, parks conflicting requests in a small FIFO, marks the first touch of
// each bucket as a load, and pulses done once every result has retired.
module msm_bucket_scheduler #(
  parameter int WINDOW_BITS = 4,
  parameter int IDX_WIDTH   = 16,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  output logic                   busy,
  output logic                   done,
  output logic                   err,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WINDOW_BITS-1:0] in_digit,
  input  logic [IDX_WIDTH-1:0]   in_idx,
  input  logic                   in_last,
  output logic                   add_valid,
  input  logic                   add_ready,
  output logic [WINDOW_BITS-1:0] add_bucket,
  output logic [IDX_WIDTH-1:0]   add_idx,
  output logic                   add_init,
  input  logic                   ret_valid,
  input  logic [WINDOW_BITS-1:0] ret_bucket
);

  localparam int NUM_BUCKETS = 1 << WINDOW_BITS;
  localparam int PTR_W       = $clog2(FIFO_DEPTH);
  localparam int FCNT_W      = PTR_W + 1;
  localparam int CNT_W       = WINDOW_BITS + 1;
  localparam logic [FCNT_W-1:0] FIFO_FULL_CNT = FCNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t state, state_nxt;

  logic [NUM_BUCKETS-1:0] bucket_busy, busy_nxt, touched;
  logic [WINDOW_BITS-1:0] fifo_bucket [FIFO_DEPTH];
  logic [IDX_WIDTH-1:0]   fifo_idx    [FIFO_DEPTH];
  logic [PTR_W-1:0]       wr_ptr, rd_ptr;
  logic [FCNT_W-1:0]      fifo_count;
  logic [CNT_W-1:0]       outstanding;

  logic                   start_clear;
  logic                   fifo_empty, fifo_full;
  logic [WINDOW_BITS-1:0] head_bucket;
  logic [IDX_WIDTH-1:0]   head_idx;
  logic                   can_load, pop, in_nz, in_can_issue, in_can_push;
  logic                   accept, in_load, push, load;
  logic [WINDOW_BITS-1:0] load_bucket;
  logic [IDX_WIDTH-1:0]   load_idx;
  logic                   ret_ok;

  assign busy = (state != S_IDLE);
  assign done = (state == S_DONE);

  // Issue arbitration: FIFO head first, then a fresh input, then park the input.
  always_comb begin
    start_clear  = (state == S_IDLE) && start;
    fifo_empty   = (fifo_count == '0);
    fifo_full    = (fifo_count == FIFO_FULL_CNT);
    head_bucket  = fifo_bucket[rd_ptr];
    head_idx     = fifo_idx[rd_ptr];
    can_load     = !add_valid || add_ready;
    pop          = can_load && !fifo_empty && !bucket_busy[head_bucket];
    in_nz        = (in_digit != '0);
    in_can_issue = can_load && !pop && !bucket_busy[in_digit] &&
                   (fifo_empty || (in_digit != head_bucket));
    in_can_push  = !in_can_issue && (!fifo_full || pop);
    in_ready     = (state == S_RUN) && (!in_nz || in_can_issue || in_can_push);
    accept       = in_valid && in_ready;
    in_load      = accept && in_nz && in_can_issue;
    push         = accept && in_nz && !in_can_issue;
    load         = pop || in_load;
    load_bucket  = pop ? head_bucket : in_digit;
    load_idx     = pop ? head_idx : in_idx;
    ret_ok       = ret_valid && bucket_busy[ret_bucket];
    busy_nxt     = bucket_busy;
    if (ret_valid) busy_nxt[ret_bucket] = 1'b0;
    if (load)      busy_nxt[load_bucket] = 1'b1;
  end

  // Window sequencing: run until in_last, then drain until everything retires.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_RUN;
      S_RUN:   if (accept && in_last) state_nxt = S_DRAIN;
      S_DRAIN: if (fifo_empty && !add_valid && (outstanding == '0)) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Bucket bookkeeping: in-flight bitmap, first-touch bitmap, outstanding count, sticky error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bucket_busy <= '0;
      touched     <= '0;
      outstanding <= '0;
      err         <= 1'b0;
    end else if (start_clear) begin
      bucket_busy <= '0;
      touched     <= '0;
      outstanding <= '0;
      err         <= 1'b0;
    end else begin
      bucket_busy <= busy_nxt;
      if (load) touched[load_bucket] <= 1'b1;
      outstanding <= outstanding + CNT_W'(load) - CNT_W'(ret_ok);
      if (ret_valid && !bucket_busy[ret_bucket]) err <= 1'b1;
    end
  end

  // Issue register toward the adder; payload holds until the adder takes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      add_valid  <= 1'b0;
      add_bucket <= '0;
      add_idx    <= '0;
      add_init   <= 1'b0;
    end else if (start_clear) begin
      add_valid <= 1'b0;
    end else if (load) begin
      add_valid  <= 1'b1;
      add_bucket <= load_bucket;
      add_idx    <= load_idx;
      add_init   <= !touched[load_bucket];
    end else if (add_ready) begin
      add_valid <= 1'b0;
    end
  end

  // Conflict FIFO pointers and occupancy; push and pop may share a cycle even when full.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else if (start_clear) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      fifo_count <= fifo_count + FCNT_W'(push) - FCNT_W'(pop);
    end
  end

  // Conflict FIFO storage; contents are only meaningful below the occupancy count.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_bucket[wr_ptr] <= in_digit;
      fifo_idx[wr_ptr]    <= in_idx;
    end
  end

endmodule

// File: tb/tb_msm_bucket_scheduler.sv
// tb_msm_bucket_scheduler: randomized and directed stimulus for the bucket
// scheduler, checked every cycle against a queue-based behavioural model plus an
// end-of-window scoreboard (every non-zero element issued once, one init per bucket).
module tb_msm_bucket_scheduler;

  localparam int WB = 4;
  localparam int IW = 16;
  localparam int FD = 4;

  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_DRAIN = 2;
  localparam int M_DONE  = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          start = 1'b0;
  logic          busy, done, err;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [WB-1:0] in_digit = '0;
  logic [IW-1:0] in_idx = '0;
  logic          in_last = 1'b0;
  logic          add_valid;
  logic          add_ready = 1'b0;
  logic [WB-1:0] add_bucket;
  logic [IW-1:0] add_idx;
  logic          add_init;
  logic          ret_valid = 1'b0;
  logic [WB-1:0] ret_bucket = '0;

  msm_bucket_scheduler #(.WINDOW_BITS(WB), .IDX_WIDTH(IW), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done), .err(err),
    .in_valid(in_valid), .in_ready(in_ready), .in_digit(in_digit), .in_idx(in_idx),
    .in_last(in_last), .add_valid(add_valid), .add_ready(add_ready),
    .add_bucket(add_bucket), .add_idx(add_idx), .add_init(add_init),
    .ret_valid(ret_valid), .ret_bucket(ret_bucket)
  );

  always #5 clk = ~clk;

  typedef struct { logic [WB-1:0] d; logic [IW-1:0] idx; logic last; } elem_t;
  typedef struct { logic [WB-1:0] b; int due; } pend_t;
  typedef struct { logic [WB-1:0] b; logic [IW-1:0] idx; logic init; int cyc; } issue_t;
  typedef struct { logic [WB-1:0] b; logic [IW-1:0] idx; } fe_t;

  int num_checks = 0;
  int num_errors = 0;
  int cycle = 0;
  int t0 = 0;
  int done_cycle = -1;

  elem_t  stream[$];
  pend_t  pending[$];
  issue_t issue_log[$];
  int     ret_log[$];
  int     acc_cycles[$];
  int     acc_count[int];

  int valid_pct = 100;
  int ready_pct = 100;
  int dly_min = 8;
  int dly_max = 8;
  bit ret_enable = 1'b1;
  bit start_req = 1'b0;
  bit spur_req = 1'b0;
  logic [WB-1:0] spur_bucket = '0;

  // Behavioural model of the scheduler state
  int            m_state;
  bit            m_busy[16];
  bit            m_touched[16];
  fe_t           m_fifo[$];
  int            m_out;
  bit            m_err, m_av, m_init;
  logic [WB-1:0] m_ab;
  logic [IW-1:0] m_ai;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    num_checks++;
    if (actual !== expected) begin
      num_errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, actual, expected, cycle);
    end
  endtask

  function automatic void modelReset();
    m_state = M_IDLE;
    for (int i = 0; i < 16; i++) begin
      m_busy[i] = 1'b0;
      m_touched[i] = 1'b0;
    end
    m_fifo.delete();
    m_out = 0;
    m_err = 1'b0;
    m_av = 1'b0;
    m_init = 1'b0;
    m_ab = '0;
    m_ai = '0;
  endfunction

  task automatic checkResetOutputs();
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_err", err, 0);
    checkOutput("rst_add_valid", add_valid, 0);
    checkOutput("rst_add_init", add_init, 0);
    checkOutput("rst_add_bucket", add_bucket, 0);
    checkOutput("rst_add_idx", add_idx, 0);
    checkOutput("rst_in_ready", in_ready, 0);
  endtask

  // One clock cycle: drive inputs, compare against the model, advance the model.
  task automatic applyStimulus();
    elem_t e;
    bit have, can_load, pop, nz, clash, in_issue, room, exp_ready, accept, drain_ok, is_load;
    logic [WB-1:0] lb;
    logic [IW-1:0] li;
    int pick;
    have = (stream.size() > 0);
    if (have) e = stream[0];
    in_valid = have && (int'($urandom_range(0, 99)) < valid_pct);
    in_digit = have ? e.d : '0;
    in_idx   = have ? e.idx : '0;
    in_last  = have ? e.last : 1'b0;
    start = start_req;
    start_req = 1'b0;
    add_ready = (int'($urandom_range(0, 99)) < ready_pct);
    ret_valid = 1'b0;
    ret_bucket = '0;
    if (spur_req) begin
      ret_valid = 1'b1;
      ret_bucket = spur_bucket;
      spur_req = 1'b0;
    end else if (ret_enable) begin
      pick = -1;
      for (int i = 0; i < pending.size(); i++) begin
        if (pending[i].due <= cycle) begin
          pick = i;
          break;
        end
      end
      if (pick >= 0) begin
        ret_valid = 1'b1;
        ret_bucket = pending[pick].b;
        pending.delete(pick);
        ret_log.push_back(cycle);
      end
    end
    @(negedge clk);
    can_load  = !m_av || add_ready;
    pop       = can_load && (m_fifo.size() > 0) && !m_busy[m_fifo[0].b];
    nz        = (in_digit != 0);
    clash     = (m_fifo.size() > 0) && (m_fifo[0].b == in_digit);
    in_issue  = can_load && !pop && !m_busy[in_digit] && !clash;
    room      = (m_fifo.size() < FD) || pop;
    exp_ready = (m_state == M_RUN) && (!nz || in_issue || room);
    checkOutput("in_ready", in_ready, exp_ready);
    checkOutput("add_valid", add_valid, m_av);
    if (m_av) begin
      checkOutput("add_bucket", add_bucket, m_ab);
      checkOutput("add_idx", add_idx, m_ai);
      checkOutput("add_init", add_init, m_init);
    end
    checkOutput("busy", busy, m_state != M_IDLE);
    checkOutput("done", done, m_state == M_DONE);
    checkOutput("err", err, m_err);
    if (add_valid && add_ready) issue_log.push_back('{add_bucket, add_idx, add_init, cycle});
    if (in_valid && in_ready) begin
      acc_cycles.push_back(cycle);
      if (in_digit != 0) acc_count[int'({in_digit, in_idx})]++;
    end
    if (done) done_cycle = cycle;
    if (m_av && add_ready) pending.push_back('{m_ab, cycle + int'($urandom_range(dly_min, dly_max))});
    accept   = in_valid && exp_ready;
    drain_ok = (m_fifo.size() == 0) && !m_av && (m_out == 0);
    if (accept) void'(stream.pop_front());
    if (m_state == M_IDLE && start) begin
      for (int i = 0; i < 16; i++) begin
        m_busy[i] = 1'b0;
        m_touched[i] = 1'b0;
      end
      m_fifo.delete();
      m_out = 0;
      m_err = 1'b0;
      m_av = 1'b0;
      m_state = M_RUN;
    end else begin
      if (ret_valid) begin
        if (m_busy[ret_bucket]) begin
          m_busy[ret_bucket] = 1'b0;
          m_out--;
        end else begin
          m_err = 1'b1;
        end
      end
      is_load = 1'b0;
      lb = '0;
      li = '0;
      if (pop) begin
        lb = m_fifo[0].b;
        li = m_fifo[0].idx;
        m_fifo.delete(0);
        is_load = 1'b1;
      end else if (accept && nz && in_issue) begin
        lb = in_digit;
        li = in_idx;
        is_load = 1'b1;
      end
      if (accept && nz && !in_issue) m_fifo.push_back('{in_digit, in_idx});
      if (is_load) begin
        m_av = 1'b1;
        m_ab = lb;
        m_ai = li;
        m_init = !m_touched[lb];
        m_touched[lb] = 1'b1;
        m_busy[lb] = 1'b1;
        m_out++;
      end else if (add_ready) begin
        m_av = 1'b0;
      end
      case (m_state)
        M_RUN:   if (accept && in_last) m_state = M_DRAIN;
        M_DRAIN: if (drain_ok) m_state = M_DONE;
        M_DONE:  m_state = M_IDLE;
        default: ;
      endcase
    end
    @(posedge clk);
    #1;
    cycle++;
  endtask

  task automatic beginWindow();
    issue_log.delete();
    ret_log.delete();
    acc_cycles.delete();
    acc_count.delete();
    done_cycle = -1;
    start_req = 1'b1;
    t0 = cycle;
  endtask

  task automatic runWindow(input int budget);
    int n = 0;
    do begin
      applyStimulus();
      n++;
    end while (m_state != M_IDLE && n < budget);
    checkOutput("window_timeout", m_state, M_IDLE);
  endtask

  task automatic checkWindow();
    int nz_acc = 0;
    int leftover = 0;
    int bad_init = 0;
    bit seen[16];
    foreach (acc_count[k]) nz_acc += acc_count[k];
    foreach (issue_log[i]) begin
      int key;
      key = int'({issue_log[i].b, issue_log[i].idx});
      if (acc_count.exists(key)) acc_count[key]--;
      else leftover++;
      if (issue_log[i].init != !seen[issue_log[i].b]) bad_init++;
      seen[issue_log[i].b] = 1'b1;
    end
    foreach (acc_count[k]) if (acc_count[k] != 0) leftover++;
    checkOutput("sb_issue_count", issue_log.size(), nz_acc);
    checkOutput("sb_unmatched", leftover, 0);
    checkOutput("sb_init_flags", bad_init, 0);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int len;
    modelReset();
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkResetOutputs();
    rst_n = 1'b1;

    // Idle: a valid element without start must not be taken
    stream.push_back('{4'd3, 16'd9, 1'b0});
    repeat (4) applyStimulus();
    checkOutput("idle_no_accept", acc_cycles.size(), 0);
    checkOutput("idle_add_valid", add_valid, 0);
    stream.delete();

    // Distinct digits: consecutive issues, all loads, done two cycles after last retire
    ready_pct = 100; dly_min = 8; dly_max = 8; ret_enable = 1'b1;
    beginWindow();
    stream.push_back('{4'd1, 16'd10, 1'b0});
    stream.push_back('{4'd2, 16'd11, 1'b0});
    stream.push_back('{4'd3, 16'd12, 1'b1});
    runWindow(200);
    checkOutput("dist_issue_count", issue_log.size(), 3);
    for (int i = 0; i < 3 && i < issue_log.size(); i++) begin
      checkOutput("dist_issue_cycle", issue_log[i].cyc, t0 + 2 + i);
      checkOutput("dist_issue_idx", issue_log[i].idx, 10 + i);
      checkOutput("dist_issue_init", issue_log[i].init, 1);
    end
    if (ret_log.size() == 3) checkOutput("dist_done_cycle", done_cycle, ret_log[2] + 2);
    checkWindow();

    // Same-bucket conflict: parked entries issue two cycles after each retire, in order
    beginWindow();
    stream.push_back('{4'd5, 16'd1, 1'b0});
    stream.push_back('{4'd5, 16'd2, 1'b0});
    stream.push_back('{4'd5, 16'd3, 1'b1});
    runWindow(300);
    checkOutput("conf_issue_count", issue_log.size(), 3);
    for (int i = 0; i < 3 && i < issue_log.size(); i++) begin
      checkOutput("conf_order_idx", issue_log[i].idx, i + 1);
      checkOutput("conf_init", issue_log[i].init, i == 0);
    end
    if (issue_log.size() == 3 && ret_log.size() >= 2) begin
      checkOutput("conf_idx2_cycle", issue_log[1].cyc, ret_log[0] + 2);
      checkOutput("conf_idx3_cycle", issue_log[2].cyc, ret_log[1] + 2);
    end
    checkWindow();

    // FIFO full: one issue, four parked, sixth stalls until the first retire
    ret_enable = 1'b0; dly_min = 3; dly_max = 3;
    beginWindow();
    for (int i = 0; i < 6; i++) stream.push_back('{4'd7, 16'(100 + i), i == 5});
    repeat (12) applyStimulus();
    checkOutput("full_issue_count", issue_log.size(), 1);
    checkOutput("full_accepted", acc_cycles.size(), 5);
    checkOutput("full_in_ready", in_ready, 0);
    ret_enable = 1'b1;
    runWindow(300);
    if (acc_cycles.size() == 6 && ret_log.size() > 0)
      checkOutput("full_sixth_accept", acc_cycles[5], ret_log[0] + 1);
    checkOutput("full_total_issues", issue_log.size(), 6);
    for (int i = 0; i < issue_log.size(); i++) begin
      checkOutput("full_order_idx", issue_log[i].idx, 100 + i);
      checkOutput("full_init", issue_log[i].init, i == 0);
    end
    checkWindow();

    // Digit 0 with in_last under adder backpressure
    ready_pct = 0; dly_min = 4; dly_max = 4;
    beginWindow();
    stream.push_back('{4'd9, 16'd50, 1'b0});
    stream.push_back('{4'd0, 16'd51, 1'b1});
    repeat (8) applyStimulus();
    checkOutput("d0_accepted", acc_cycles.size(), 2);
    if (acc_cycles.size() == 2) checkOutput("d0_accept_cycle", acc_cycles[1], t0 + 2);
    checkOutput("d0_no_issue", issue_log.size(), 0);
    checkOutput("d0_hold_valid", add_valid, 1);
    checkOutput("d0_hold_bucket", add_bucket, 9);
    checkOutput("d0_hold_idx", add_idx, 50);
    checkOutput("d0_still_busy", busy, 1);
    ready_pct = 100;
    runWindow(200);
    checkOutput("d0_issue_count", issue_log.size(), 1);
    if (ret_log.size() == 1) checkOutput("d0_done_cycle", done_cycle, ret_log[0] + 2);
    checkWindow();

    // Spurious retire for an idle bucket: sticky err, outstanding count untouched
    dly_min = 10; dly_max = 10;
    beginWindow();
    stream.push_back('{4'd6, 16'd70, 1'b1});
    repeat (4) applyStimulus();
    spur_req = 1'b1;
    spur_bucket = 4'd3;
    applyStimulus();
    checkOutput("err_set", err, 1);
    runWindow(200);
    if (ret_log.size() == 1) checkOutput("err_done_cycle", done_cycle, ret_log[0] + 2);
    checkOutput("err_sticky", err, 1);
    checkWindow();

    // Asynchronous reset in the middle of a window
    valid_pct = 100; ready_pct = 50; dly_min = 2; dly_max = 6;
    beginWindow();
    for (int i = 0; i < 10; i++) stream.push_back('{4'($urandom_range(0, 15)), 16'($urandom), i == 9});
    repeat (6) applyStimulus();
    #2 rst_n = 1'b0;
    #1;
    checkResetOutputs();
    modelReset();
    pending.delete();
    stream.delete();
    in_valid = 1'b0; start = 1'b0; ret_valid = 1'b0; add_ready = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    stream.push_back('{4'd2, 16'd5, 1'b0});
    repeat (3) applyStimulus();
    stream.delete();

    // Randomized windows
    valid_pct = 75; ready_pct = 60; dly_min = 1; dly_max = 10;
    for (int w = 0; w < 6; w++) begin
      beginWindow();
      len = int'($urandom_range(4, 24));
      for (int i = 0; i < len; i++)
        stream.push_back('{4'($urandom_range(0, 15)), 16'($urandom), i == len - 1});
      runWindow(3000);
      checkWindow();
    end

    $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
    $finish;
  end

endmodule
